line_fetch_scheduler: RTL and testbench
=======================================

# line_fetch_scheduler

Runs in the VGA pixel domain and sequences the SDRAM line reader. Decides which source image row must be fetched next and into which half of the ping-pong line buffer, and drives a 4-phase req/ack handshake across to the SDRAM clock domain. Swaps the display/fill buffers at line start and flags underruns when a fetch finishes too late. Supports 320×240 source on a 640×480 raster, with optional vertical line doubling.

## Interface
Parameters:
- IMG_HEIGHT, 240, source image rows.
- V_ACTIVE, 480, visible display lines.
- V_TOTAL, 525, total lines per frame.
- LINE_REPEAT, 2, display lines per source row; legal values 1 or 2 only (row = y >> (LINE_REPEAT-1)).

Ports:
- clk_vga  in  1  pixel clock, 25 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; low blocks new fetches and blanks output.
- x  in  10  current pixel column.
- y  in  10  current display line.
- frame_start  in  1  one-cycle pulse at x=0, y=0.
- fetch_req  out  1  4-phase request to SDRAM domain.
- fetch_row  out  9  source row to fetch; stable while fetch_req or ack is high.
- fetch_buf  out  1  buffer half to fill; stable with fetch_row.
- fetch_ack_async  in  1  level ack from SDRAM domain, unsynchronized.
- disp_buf  out  1  buffer half the VGA side reads.
- line_valid  out  1  current line has valid data; low = blank.
- underrun  out  1  one-cycle pulse on a missed swap.
- underrun_cnt  out  16  saturating underrun count.
- busy  out  1  handshake in progress (state ≠ IDLE).

## Operation
- Synchronize fetch_ack_async through 2 flops to get ack_s. All logic uses ack_s only.
- Line-start event: ls = (x==0) && (x_q≠0), where x_q is x registered.
- Internal registers: disp_row, fill_row, next_row (9 b, ROW_INVALID = 0x1FF), and fill_done.
- frame_start sets disp_row = ROW_INVALID. This is applied before the swap evaluation in the same cycle. It does not touch fill_row or the FSM.
- At ls on line y, compute:
  - need_now = row(y) if y < V_ACTIVE and row(y) < IMG_HEIGHT, else none.
  - need_next: the same function of (y+1), with y = V_TOTAL-1 wrapping to 0.
- Swap step at ls:
  - need_now none: line_valid = 0.
  - need_now == disp_row: line_valid = 1, no swap.
  - fill_row == need_now and fill_done: toggle disp_buf, set disp_row = need_now, line_valid = 1.
  - Otherwise: line_valid = 0, pulse underrun, increment underrun_cnt (saturates at 0xFFFF).
- Schedule step at ls: next_row = need_next, or ROW_INVALID if none.
- FSM (state_t):
  - IDLE: if enable, next_row valid, next_row ≠ disp_row and next_row ≠ fill_row, then:
    - load fetch_row = next_row and fetch_buf = ~disp_buf;
    - set fill_row = next_row and fill_done = 0;
    - go to REQ.
  - REQ: assert fetch_req; go to WAIT_ACK.
  - WAIT_ACK: hold fetch_req until ack_s = 1, then deassert it, set fill_done = 1, go to WAIT_DROP.
  - WAIT_DROP: wait for ack_s = 0, then go to IDLE.
- IDLE evaluates every cycle, so a fetch blocked at ls starts as soon as the FSM returns to IDLE.
- A swap only succeeds when fill_done = 1, which implies state is WAIT_DROP or IDLE. The fill half is therefore never the displayed half during an active fill.
- enable low: no IDLE→REQ transition, and line_valid is forced to 0 at the next ls. An in-flight handshake always completes.
- With LINE_REPEAT = 2, the second display line of each pair hits the need_now == disp_row case.

## Timing
- Reset values:
  - fetch_req, fetch_row, fetch_buf, disp_buf, line_valid, underrun, underrun_cnt, busy are all 0.
  - disp_row, fill_row, next_row are ROW_INVALID; fill_done is 0; state is IDLE.
- disp_buf, line_valid and underrun update on the clock edge after the ls cycle, so they are valid from x = 1.
- fetch_req rises 1 cycle after the IDLE→REQ decision.
- Ack path latency: 2 cycles of synchronizer plus 1 cycle to deassert fetch_req.
- ack_s rising in the same cycle as ls: the swap sees the old fill_done = 0, which produces an underrun. This is required behaviour.
- Row 0 is prefetched at ls of line V_TOTAL-1 and swapped in at line 0.
- Reset mid-handshake: fetch_req drops immediately (async). The SDRAM side must tolerate a request abort.

## Structure
- Package vga_fetch_pkg holds state_t (IDLE, REQ, WAIT_ACK, WAIT_DROP), ROW_INVALID, and the default raster constants.
- One sub-module, sync_2ff, with a width parameter, for ack synchronization.

## Test plan
- Reset, then run a full frame with an ack model (20-cycle delay) → row 0 requested at line 524, disp_buf toggles at line 0, line_valid = 1 on lines 0–479, underrun_cnt = 0.
- LINE_REPEAT = 2 → fetch_row sequence 0,1,…,239, exactly one request per two lines, disp_buf toggles on even lines only.
- Ack delayed to 900 cycles → underrun pulses each needed line, line_valid = 0 there, underrun_cnt increments, and it saturates at 0xFFFF when forced.
- ack_s rising in the exact ls cycle → that line is an underrun; the buffer swaps on the next line's ls.
- enable deasserted mid-WAIT_ACK → the handshake completes, no new fetch_req, line_valid = 0 from the next ls.
- Assert reset_n low during REQ → all outputs return to reset values asynchronously, and the FSM restarts cleanly at the next frame.

Source files
------------

// File: rtl/vga_fetch_pkg.sv
// Shared types and raster constants for the VGA line fetch scheduler.
package vga_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DROP = 2'd3
    } state_t;

    localparam logic [8:0]  ROW_INVALID     = 9'h1FF;
    localparam int unsigned IMG_HEIGHT_DEF  = 32'd240;
    localparam int unsigned V_ACTIVE_DEF    = 32'd480;
    localparam int unsigned V_TOTAL_DEF     = 32'd525;
    localparam int unsigned LINE_REPEAT_DEF = 32'd2;

    // Source row shown on display line y, or ROW_INVALID when the line
    // lies outside the visible area or below the bottom of the image.
    function automatic logic [8:0] src_row(
        input logic [9:0]  y,
        input int unsigned line_repeat,
        input int unsigned v_active,
        input int unsigned img_height
    );
        logic [9:0] r;
        r = (line_repeat == 32'd2) ? {1'b0, y[9:1]} : y;
        if (({22'd0, y} < v_active) && ({22'd0, r} < img_height)) begin
            src_row = r[8:0];
        end else begin
            src_row = ROW_INVALID;
        end
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for level signals entering the pixel clock domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/line_fetch_scheduler.sv
// Chooses the next source row to pull from SDRAM into the fill half of the
// ping-pong line buffer, runs the 4-phase req/ack handshake, swaps halves at
// line start and flags lines whose data arrived too late.
module line_fetch_scheduler
    import vga_fetch_pkg::*;
#(
    parameter int unsigned IMG_HEIGHT  = IMG_HEIGHT_DEF,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
    parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
    parameter int unsigned LINE_REPEAT = LINE_REPEAT_DEF
) (
    input  logic        clk_vga,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        frame_start,
    output logic        fetch_req,
    output logic [8:0]  fetch_row,
    output logic        fetch_buf,
    input  logic        fetch_ack_async,
    output logic        disp_buf,
    output logic        line_valid,
    output logic        underrun,
    output logic [15:0] underrun_cnt,
    output logic        busy
);

    logic        ack_s;
    logic [9:0]  x_q_r;
    logic [8:0]  disp_row_r;
    logic [8:0]  fill_row_r;
    logic [8:0]  next_row_r;
    logic        fill_done_r;
    state_t      state_r;
    logic        fetch_req_r;
    logic [8:0]  fetch_row_r;
    logic        fetch_buf_r;
    logic        disp_buf_r;
    logic        line_valid_r;
    logic        underrun_r;
    logic [15:0] underrun_cnt_r;
    logic        busy_r;

    logic        ls_s;
    logic [9:0]  y_next_s;
    logic [8:0]  need_now_s;
    logic [8:0]  need_next_s;
    logic [8:0]  disp_row_cur_s;
    logic [8:0]  disp_row_nxt_s;
    logic        disp_buf_nxt_s;
    logic        line_valid_nxt_s;
    logic        miss_s;
    logic        start_fetch_s;

    sync_2ff #(.WIDTH(1)) u_ack_sync (
        .clk     (clk_vga),
        .reset_n (reset_n),
        .d       (fetch_ack_async),
        .q       (ack_s)
    );

    // Line-start detection and the rows needed now and on the following line.
    always_comb begin
        ls_s = (x == 10'd0) && (x_q_r != 10'd0);
        if ({22'd0, y} == (V_TOTAL - 32'd1)) begin
            y_next_s = 10'd0;
        end else begin
            y_next_s = y + 10'd1;
        end
        need_now_s  = src_row(y, LINE_REPEAT, V_ACTIVE, IMG_HEIGHT);
        need_next_s = src_row(y_next_s, LINE_REPEAT, V_ACTIVE, IMG_HEIGHT);
        // A new frame forgets the displayed row before the swap looks at it.
        disp_row_cur_s = frame_start ? ROW_INVALID : disp_row_r;
    end

    // Swap decision: keep, swap in the freshly filled half, or report a miss.
    always_comb begin
        disp_row_nxt_s   = disp_row_cur_s;
        disp_buf_nxt_s   = disp_buf_r;
        line_valid_nxt_s = line_valid_r;
        miss_s           = 1'b0;
        if (ls_s) begin
            if (!enable) begin
                line_valid_nxt_s = 1'b0;
            end else if (need_now_s == ROW_INVALID) begin
                line_valid_nxt_s = 1'b0;
            end else if (need_now_s == disp_row_cur_s) begin
                line_valid_nxt_s = 1'b1;
            end else if ((fill_row_r == need_now_s) && fill_done_r) begin
                disp_buf_nxt_s   = ~disp_buf_r;
                disp_row_nxt_s   = need_now_s;
                line_valid_nxt_s = 1'b1;
            end else begin
                line_valid_nxt_s = 1'b0;
                miss_s           = 1'b1;
            end
        end else begin
            miss_s = 1'b0;
        end
    end

    // A fetch may start only for a row that is neither shown nor already filled;
    // comparing against the post-swap view keeps the fill half off the display.
    always_comb begin
        start_fetch_s = enable
                     && (next_row_r != ROW_INVALID)
                     && (next_row_r != disp_row_nxt_s)
                     && (next_row_r != fill_row_r);
    end

    // Display-side registers: swap state, line status, underrun reporting, schedule.
    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n) begin
            x_q_r          <= 10'd0;
            disp_row_r     <= ROW_INVALID;
            disp_buf_r     <= 1'b0;
            line_valid_r   <= 1'b0;
            underrun_r     <= 1'b0;
            underrun_cnt_r <= 16'd0;
            next_row_r     <= ROW_INVALID;
        end else begin
            x_q_r        <= x;
            disp_row_r   <= disp_row_nxt_s;
            disp_buf_r   <= disp_buf_nxt_s;
            line_valid_r <= line_valid_nxt_s;
            underrun_r   <= miss_s;
            if (miss_s && (underrun_cnt_r != 16'hFFFF)) begin
                underrun_cnt_r <= underrun_cnt_r + 16'd1;
            end else begin
                underrun_cnt_r <= underrun_cnt_r;
            end
            if (ls_s) begin
                next_row_r <= need_next_s;
            end else begin
                next_row_r <= next_row_r;
            end
        end
    end

    // Fetch handshake FSM toward the SDRAM domain.
    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            fetch_req_r <= 1'b0;
            fetch_row_r <= 9'd0;
            fetch_buf_r <= 1'b0;
            fill_row_r  <= ROW_INVALID;
            fill_done_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_fetch_s) begin
                        fetch_row_r <= next_row_r;
                        fetch_buf_r <= ~disp_buf_nxt_s;
                        fill_row_r  <= next_row_r;
                        fill_done_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= REQ;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    fetch_req_r <= 1'b1;
                    busy_r      <= 1'b1;
                    state_r     <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (ack_s) begin
                        fetch_req_r <= 1'b0;
                        fill_done_r <= 1'b1;
                        state_r     <= WAIT_DROP;
                    end else begin
                        fetch_req_r <= 1'b1;
                        state_r     <= WAIT_ACK;
                    end
                end
                WAIT_DROP: begin
                    if (!ack_s) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT_DROP;
                    end
                end
                default: begin
                    fetch_req_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign fetch_req    = fetch_req_r;
    assign fetch_row    = fetch_row_r;
    assign fetch_buf    = fetch_buf_r;
    assign disp_buf     = disp_buf_r;
    assign line_valid   = line_valid_r;
    assign underrun     = underrun_r;
    assign underrun_cnt = underrun_cnt_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_line_fetch_scheduler.sv
// Directed bench for line_fetch_scheduler on a shortened 48-pixel raster line.
module tb_line_fetch_scheduler;

    localparam int H = 48;

    logic        clk_vga = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        frame_start;
    logic        fetch_req;
    logic [8:0]  fetch_row;
    logic        fetch_buf;
    logic        fetch_ack_async;
    logic        disp_buf;
    logic        line_valid;
    logic        underrun;
    logic [15:0] underrun_cnt;
    logic        busy;

    logic ack_model = 1'b0;
    logic ack_manual = 1'b0;
    logic ack_manual_mode = 1'b0;
    int   ack_delay = 20;

    int n_cmp = 0;
    int n_mis = 0;

    logic s_lv, s_db, s_ur, s_ur_late;

    logic       req_prev = 1'b0;
    logic [8:0] req_rows[$];
    int         req_ys[$];
    logic       req_bufs[$];

    assign fetch_ack_async = ack_manual_mode ? ack_manual : ack_model;

    always #20 clk_vga = ~clk_vga;

    line_fetch_scheduler dut (
        .clk_vga         (clk_vga),
        .reset_n         (reset_n),
        .enable          (enable),
        .x               (x),
        .y               (y),
        .frame_start     (frame_start),
        .fetch_req       (fetch_req),
        .fetch_row       (fetch_row),
        .fetch_buf       (fetch_buf),
        .fetch_ack_async (fetch_ack_async),
        .disp_buf        (disp_buf),
        .line_valid      (line_valid),
        .underrun        (underrun),
        .underrun_cnt    (underrun_cnt),
        .busy            (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record every new request with its row, buffer half and the display line.
    always @(negedge clk_vga) begin
        if (fetch_req && !req_prev) begin
            req_rows.push_back(fetch_row);
            req_ys.push_back(int'(y));
            req_bufs.push_back(fetch_buf);
        end
        req_prev <= fetch_req;
    end

    // SDRAM-side ack model: ack after ack_delay cycles, drop after req falls.
    always begin
        @(negedge clk_vga);
        if (fetch_req && !ack_model) begin
            for (int k = 0; k < ack_delay && fetch_req; k++) @(negedge clk_vga);
            if (fetch_req) begin
                ack_model = 1'b1;
                for (int k = 0; k < 64 && fetch_req; k++) @(negedge clk_vga);
                repeat (2) @(negedge clk_vga);
                ack_model = 1'b0;
            end
        end
    end

    task automatic reset_in_req();
        check_eq("req_busy", {31'd0, busy}, 32'd1);
        check_eq("req_fetch_req_low", {31'd0, fetch_req}, 32'd0);
        check_eq("req_fetch_row", {23'd0, fetch_row}, 32'd1);
        check_eq("req_disp_buf", {31'd0, disp_buf}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("arst_fetch_req", {31'd0, fetch_req}, 32'd0);
        check_eq("arst_fetch_row", {23'd0, fetch_row}, 32'd0);
        check_eq("arst_fetch_buf", {31'd0, fetch_buf}, 32'd0);
        check_eq("arst_disp_buf", {31'd0, disp_buf}, 32'd0);
        check_eq("arst_line_valid", {31'd0, line_valid}, 32'd0);
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_line(input int yv, input int ack_on_x, input int ack_off_x,
                            input int en_off_x, input int rst_x);
        for (int xi = 0; xi < H; xi++) begin
            @(negedge clk_vga);
            if (xi == 1) begin
                s_lv = line_valid;
                s_db = disp_buf;
                s_ur = underrun;
            end
            if ((xi == 2) && underrun) s_ur_late = 1'b1;
            if (xi == ack_on_x) ack_manual = 1'b1;
            if (xi == ack_off_x) ack_manual = 1'b0;
            if (xi == en_off_x) enable = 1'b0;
            if (xi == rst_x) reset_in_req();
            x = 10'(xi);
            y = 10'(yv);
            frame_start = (xi == 0) && (yv == 0);
        end
    endtask

    task automatic run_plain(input int yv);
        run_line(yv, -1, -1, -1, -1);
    endtask

    task automatic do_reset();
        @(negedge clk_vga);
        reset_n = 1'b0;
        enable = 1'b1;
        x = 10'd0;
        y = 10'd0;
        frame_start = 1'b0;
        repeat (3) @(negedge clk_vga);
        reset_n = 1'b1;
    endtask

    initial begin
        int n_lv_in, n_lv_out, tog_even, tog_odd, n_ur, seq_err, nreq;
        logic prev_db, line0_db;

        reset_n = 1'b0;
        enable = 1'b1;
        x = 10'd0;
        y = 10'd0;
        frame_start = 1'b0;
        s_ur_late = 1'b0;
        repeat (3) @(negedge clk_vga);

        // Reset values
        check_eq("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
        check_eq("rst_fetch_row", {23'd0, fetch_row}, 32'd0);
        check_eq("rst_fetch_buf", {31'd0, fetch_buf}, 32'd0);
        check_eq("rst_disp_buf", {31'd0, disp_buf}, 32'd0);
        check_eq("rst_line_valid", {31'd0, line_valid}, 32'd0);
        check_eq("rst_underrun", {31'd0, underrun}, 32'd0);
        check_eq("rst_underrun_cnt", {16'd0, underrun_cnt}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;

        // Full frame with a 20-cycle ack, line doubling
        run_plain(523);
        run_plain(524);
        prev_db = s_db;
        line0_db = 1'b0;
        n_lv_in = 0; n_lv_out = 0; tog_even = 0; tog_odd = 0; n_ur = 0;
        for (int yy = 0; yy < 525; yy++) begin
            run_plain(yy);
            if (yy == 0) line0_db = s_db;
            if (s_lv) begin
                if (yy < 480) n_lv_in++;
                else n_lv_out++;
            end
            if (s_db != prev_db) begin
                if ((yy % 2) == 0) tog_even++;
                else tog_odd++;
            end
            prev_db = s_db;
            if (s_ur) n_ur++;
        end
        check_eq("t2_line0_disp_buf", {31'd0, line0_db}, 32'd1);
        check_eq("t2_valid_active", 32'(n_lv_in), 32'd480);
        check_eq("t2_valid_blank", 32'(n_lv_out), 32'd0);
        check_eq("t2_toggle_even", 32'(tog_even), 32'd240);
        check_eq("t2_toggle_odd", 32'(tog_odd), 32'd0);
        check_eq("t2_underrun_pulses", 32'(n_ur), 32'd0);
        check_eq("t2_underrun_cnt", {16'd0, underrun_cnt}, 32'd0);
        check_eq("t2_req_count", 32'(req_rows.size()), 32'd241);
        seq_err = 0;
        for (int k = 0; k < req_rows.size() && k < 241; k++) begin
            int er, ey;
            er = ((k == 0) || (k == 240)) ? 0 : k;
            ey = ((k == 0) || (k == 240)) ? 524 : (2 * k - 1);
            if (int'(req_rows[k]) != er) seq_err++;
            if (req_ys[k] != ey) seq_err++;
            if (req_bufs[k] != ((k % 2) == 0)) seq_err++;
        end
        check_eq("t2_req_sequence_errors", 32'(seq_err), 32'd0);

        // Slow ack: underruns on every line needing the late row
        ack_delay = 900;
        n_ur = 0; n_lv_in = 0; s_ur_late = 1'b0;
        for (int yy = 0; yy < 10; yy++) begin
            run_plain(yy);
            if (yy < 2) begin
                check_eq("t3_head_valid", {31'd0, s_lv}, 32'd1);
            end else begin
                if (s_ur) n_ur++;
                if (s_lv) n_lv_in++;
            end
        end
        check_eq("t3_underrun_pulses", 32'(n_ur), 32'd8);
        check_eq("t3_valid_on_missed", 32'(n_lv_in), 32'd0);
        check_eq("t3_pulse_width", {31'd0, s_ur_late}, 32'd0);
        check_eq("t3_underrun_cnt", {16'd0, underrun_cnt}, 32'd8);
        force dut.underrun_cnt_r = 16'hFFFE;
        @(negedge clk_vga);
        release dut.underrun_cnt_r;
        run_plain(10);
        check_eq("t3_cnt_to_max", {16'd0, underrun_cnt}, 32'hFFFF);
        run_plain(11);
        check_eq("t3_cnt_saturated", {16'd0, underrun_cnt}, 32'hFFFF);
        check_eq("t3_pulse_at_max", {31'd0, s_ur}, 32'd1);

        // ack_s rising in the very line-start cycle
        do_reset();
        ack_manual = 1'b0;
        ack_manual_mode = 1'b1;
        run_plain(523);
        run_line(524, H - 2, -1, -1, -1);
        run_line(0, -1, 10, -1, -1);
        check_eq("t4_l0_underrun", {31'd0, s_ur}, 32'd1);
        check_eq("t4_l0_valid", {31'd0, s_lv}, 32'd0);
        check_eq("t4_l0_disp_buf", {31'd0, s_db}, 32'd0);
        run_plain(1);
        check_eq("t4_l1_underrun", {31'd0, s_ur}, 32'd0);
        check_eq("t4_l1_valid", {31'd0, s_lv}, 32'd1);
        check_eq("t4_l1_disp_buf", {31'd0, s_db}, 32'd1);
        check_eq("t4_underrun_cnt", {16'd0, underrun_cnt}, 32'd1);

        // enable dropped while waiting for ack
        do_reset();
        ack_manual_mode = 1'b0;
        ack_delay = 20;
        run_plain(523);
        run_plain(524);
        run_plain(0);
        run_line(1, -1, -1, 10, -1);
        check_eq("t5_l1_valid", {31'd0, s_lv}, 32'd1);
        check_eq("t5_hs_done_req", {31'd0, fetch_req}, 32'd0);
        check_eq("t5_hs_done_busy", {31'd0, busy}, 32'd0);
        nreq = req_rows.size();
        n_lv_in = 0;
        for (int yy = 2; yy < 6; yy++) begin
            run_plain(yy);
            if (s_lv) n_lv_in++;
        end
        check_eq("t5_valid_lines", 32'(n_lv_in), 32'd0);
        check_eq("t5_new_requests", 32'(req_rows.size() - nreq), 32'd0);
        check_eq("t5_disp_buf", {31'd0, disp_buf}, 32'd1);
        check_eq("t5_underrun_cnt", {16'd0, underrun_cnt}, 32'd0);

        // Asynchronous reset during REQ, then a clean restart
        do_reset();
        run_plain(523);
        run_plain(524);
        run_plain(0);
        run_line(1, -1, -1, -1, 2);
        @(negedge clk_vga);
        reset_n = 1'b1;
        nreq = req_rows.size();
        run_plain(523);
        run_plain(524);
        run_plain(0);
        check_eq("t6_l0_valid", {31'd0, s_lv}, 32'd1);
        check_eq("t6_l0_disp_buf", {31'd0, s_db}, 32'd1);
        run_plain(1);
        run_plain(2);
        check_eq("t6_l2_valid", {31'd0, s_lv}, 32'd1);
        check_eq("t6_l2_disp_buf", {31'd0, s_db}, 32'd0);
        check_eq("t6_new_requests", 32'(req_rows.size() - nreq), 32'd2);
        if (req_rows.size() > 0) begin
            check_eq("t6_last_row", {23'd0, req_rows[req_rows.size() - 1]}, 32'd1);
        end else begin
            check_eq("t6_last_row_missing", 32'd0, 32'd1);
        end
        check_eq("t6_underrun_cnt", {16'd0, underrun_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
